// File: rtl/keypad_sequencer_if.sv
// Keypad replay bus: passcode request in, one-hot key strobes and status out.
// The repeats field exists only when ATTEMPT_LOOP_EN is defined.
interface keypad_sequencer_if #(
  parameter int unsigned DIGITS = 8
);
  logic                start;
  logic [4*DIGITS-1:0] code;
`ifdef ATTEMPT_LOOP_EN
  logic [2:0]          repeats;
`endif
  logic [9:0]          key;
  logic                busy;
  logic                done;
  logic                err;

`ifdef ATTEMPT_LOOP_EN
  modport master (output start, code, repeats, input key, busy, done, err);
  modport slave  (input start, code, repeats, output key, busy, done, err);
`else
  modport master (output start, code, input key, busy, done, err);
  modport slave  (input start, code, output key, busy, done, err);
`endif
endinterface

// File: rtl/keypad_sequencer.sv
// Replays a packed BCD passcode as timed one-hot press/release strobes on a 10-line keypad bus.
// Optional ATTEMPT_LOOP_EN adds a 3-bit repeat count so the code is replayed repeats+1 times.
module keypad_sequencer #(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned PRESS_CYCLES = 1,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input logic               clk,
  input logic               rst_n,
  keypad_sequencer_if.slave bus
);

  localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PressW = (PRESS_CYCLES > 1) ? $clog2(PRESS_CYCLES) : 1;
  localparam int unsigned GapW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(DIGITS - 1);
  localparam logic [PressW-1:0] PressLast = PressW'(PRESS_CYCLES - 1);
  localparam logic [GapW-1:0]   GapLast   = GapW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StPress, StGap, StFin} state_e;

  state_e                 state_q, state_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [PressW-1:0]      press_cnt_q, press_cnt_d;
  logic [GapW-1:0]        gap_cnt_q, gap_cnt_d;
  // Stored in press order: shadow_q[0] is the first digit pressed.
  logic [DIGITS-1:0][3:0] shadow_q, shadow_d;
  logic                   err_q, err_d;
  logic [3:0]             cur_digit;
  logic                   cur_bad;
  logic                   last_pass;

`ifdef ATTEMPT_LOOP_EN
  logic [2:0] rpt_q, rpt_d;
  logic [2:0] pass_q, pass_d;

  assign last_pass = (pass_q == rpt_q);
`else
  assign last_pass = 1'b1;
`endif

  assign cur_digit = shadow_q[idx_q];
  assign cur_bad   = (cur_digit > 4'd9);

  // The bad-digit term makes err visible from the first cycle of the offending slot.
  assign bus.err = err_q | ((state_q == StPress) & cur_bad);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    press_cnt_d = press_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    shadow_d    = shadow_q;
    err_d       = err_q;
`ifdef ATTEMPT_LOOP_EN
    rpt_d       = rpt_q;
    pass_d      = pass_q;
`endif
    bus.key     = '0;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          for (int unsigned i = 0; i < DIGITS; i++) begin
            shadow_d[i] = bus.code[4*(DIGITS-1-i) +: 4];
          end
          idx_d       = '0;
          press_cnt_d = '0;
          gap_cnt_d   = '0;
          err_d       = 1'b0;
`ifdef ATTEMPT_LOOP_EN
          rpt_d       = bus.repeats;
          pass_d      = '0;
`endif
          state_d     = StPress;
        end
      end

      StPress: begin
        bus.busy = 1'b1;
        if (cur_bad) begin
          err_d = 1'b1;
        end else begin
          bus.key = 10'b1 << cur_digit;
        end
        if (press_cnt_q == PressLast) begin
          press_cnt_d = '0;
          state_d     = StGap;
        end else begin
          press_cnt_d = press_cnt_q + 1'b1;
        end
      end

      StGap: begin
        bus.busy = 1'b1;
        if (gap_cnt_q == GapLast) begin
          gap_cnt_d = '0;
          if (idx_q == IdxLast) begin
            idx_d = '0;
            if (last_pass) begin
              state_d = StFin;
            end else begin
              // Next pass starts straight away with no idle cycle in between.
              state_d = StPress;
`ifdef ATTEMPT_LOOP_EN
              pass_d  = pass_q + 3'd1;
`endif
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StPress;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      StFin: begin
        bus.done = 1'b1;
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      press_cnt_q <= '0;
      gap_cnt_q   <= '0;
      shadow_q    <= '0;
      err_q       <= 1'b0;
`ifdef ATTEMPT_LOOP_EN
      rpt_q       <= '0;
      pass_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      press_cnt_q <= press_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      shadow_q    <= shadow_d;
      err_q       <= err_d;
`ifdef ATTEMPT_LOOP_EN
      rpt_q       <= rpt_d;
      pass_q      <= pass_d;
`endif
    end
  end

endmodule
